// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its PLL/system side.
// slave = sequencer view, master = PLL and reset-consumer view.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       reconfig_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       timeout_err;
    logic [7:0] relock_count;
    logic [1:0] state;

    modport slave (
        input  pll_locked,
        input  reconfig_req,
        output pll_rst,
        output sys_reset,
        output ready,
        output timeout_err,
        output relock_count,
        output state
    );

    modport master (
        output pll_locked,
        output reconfig_req,
        input  pll_rst,
        input  sys_reset,
        input  ready,
        input  timeout_err,
        input  relock_count,
        input  state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// ECP5 PLL reset sequencer: pulses PLL RST, qualifies LOCK, releases sys_reset after stable lock + hold.
// Latency: RST_CYCLES + LOCK_STABLE + HOLD_CYCLES cycles from reset release to ready with lock already up.
// No backpressure: reconfig_req is a single-cycle strobe, honoured outside RESET, ignored inside it.
module pll_reset_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 250000,
    parameter int LOCK_STABLE  = 1024,
    parameter int HOLD_CYCLES  = 64,
    parameter int LOSS_FILTER  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    pll_reset_sequencer_if.slave    bus
);

    localparam int CNT_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > HOLD_CYCLES) ? CNT_MAX0 : HOLD_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;
    localparam int STB_W    = $clog2(LOCK_STABLE) + 1;
    localparam int LOSS_W   = $clog2(LOSS_FILTER) + 1;

    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STB_W-1:0]    stable_cnt_q, stable_cnt_d;
    logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_reset_q, sys_reset_d;
    logic                ready_q, ready_d;
    logic                timeout_err_q, timeout_err_d;
    logic [7:0]          relock_count_q, relock_count_d;

    logic                locked_s;
    logic                reconfig;
    logic                timeout_evt;
    logic                loss_evt;
    logic                state_chg;

    assign locked_s = sync_q[1];
    assign reconfig = bus.reconfig_req;

    always_comb begin
        sync_d = {sync_q[0], bus.pll_locked};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. reconfig_req outranks every other exit; lock outranks timeout.
    always_comb begin
        state_d     = state_q;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (reconfig) begin
                    state_d = ST_RESET;
                end else if (locked_s && (stable_cnt_q == STB_LAST)) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = ST_RESET;
                    timeout_evt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (reconfig) begin
                    state_d = ST_RESET;
                end else if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reconfig) begin
                    state_d = ST_RESET;
                end else if (!locked_s && (loss_cnt_q == LOSS_LAST)) begin
                    state_d  = ST_RESET;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Outputs and counters, all decoded from the next state so they move with state_q.
    always_comb begin
        state_chg = (state_d != state_q);

        cnt_d        = cnt_q;
        stable_cnt_d = '0;
        loss_cnt_d   = '0;
        if (state_chg) begin
            cnt_d = '0;
        end else begin
            if (state_q != ST_RUN) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((state_q == ST_WAIT_LOCK) && locked_s) begin
                stable_cnt_d = stable_cnt_q + STB_W'(1);
            end
            if ((state_q == ST_RUN) && !locked_s) begin
                loss_cnt_d = loss_cnt_q + LOSS_W'(1);
            end
        end

        pll_rst_d     = (state_d == ST_RESET);
        sys_reset_d   = (state_d != ST_RUN);
        ready_d       = (state_d == ST_RUN);
        timeout_err_d = timeout_err_q | timeout_evt;

        relock_count_d = relock_count_q;
        if ((timeout_evt || loss_evt) && (relock_count_q != 8'hFF)) begin
            relock_count_d = relock_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q         <= 2'b00;
            cnt_q          <= '0;
            stable_cnt_q   <= '0;
            loss_cnt_q     <= '0;
            pll_rst_q      <= 1'b1;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
            timeout_err_q  <= 1'b0;
            relock_count_q <= 8'd0;
        end else begin
            sync_q         <= sync_d;
            cnt_q          <= cnt_d;
            stable_cnt_q   <= stable_cnt_d;
            loss_cnt_q     <= loss_cnt_d;
            pll_rst_q      <= pll_rst_d;
            sys_reset_q    <= sys_reset_d;
            ready_q        <= ready_d;
            timeout_err_q  <= timeout_err_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_reset    = sys_reset_q;
    assign bus.ready        = ready_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.relock_count = relock_count_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters; per-cycle expectations go
// through a scoreboard queue and are checked with immediate assertions at the negedge.
module tb_pll_reset_sequencer;

    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    typedef struct packed {
        logic [1:0] st;
        logic       pr;
        logic       sr;
        logic       rd;
        logic       te;
        logic [7:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    pll_reset_sequencer_if sif ();

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .LOCK_STABLE  (8),
        .HOLD_CYCLES  (5),
        .LOSS_FILTER  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #20 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         phase = 0;
    string      step = "init";
    logic [7:0] exp_relock = 8'd0;
    logic       exp_terr = 1'b0;
    exp_t       sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Each cycle: optionally drive the 7-high/1-low lock pattern, push the expected
    // outputs for this cycle, then pop and compare against what the DUT shows.
    task automatic run_cycles(input int n, input logic [1:0] st, input bit toggle);
        exp_t e;
        exp_t got;
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                sif.pll_locked = ((phase % 8) != 0);
                phase++;
            end
            e.st = st;
            e.pr = (st == S_RST);
            e.sr = (st != S_RUN);
            e.rd = (st == S_RUN);
            e.te = exp_terr;
            e.rc = exp_relock;
            sb.push_back(e);
            got = sb.pop_front();
            chk($sformatf("%s c%0d state", step, cyc),        32'(sif.state),        32'(got.st));
            chk($sformatf("%s c%0d pll_rst", step, cyc),      32'(sif.pll_rst),      32'(got.pr));
            chk($sformatf("%s c%0d sys_reset", step, cyc),    32'(sif.sys_reset),    32'(got.sr));
            chk($sformatf("%s c%0d ready", step, cyc),        32'(sif.ready),        32'(got.rd));
            chk($sformatf("%s c%0d timeout_err", step, cyc),  32'(sif.timeout_err),  32'(got.te));
            chk($sformatf("%s c%0d relock_count", step, cyc), 32'(sif.relock_count), 32'(got.rc));
            tick();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " state"},        32'(sif.state),        32'd0);
        chk({tag, " pll_rst"},      32'(sif.pll_rst),      32'd1);
        chk({tag, " sys_reset"},    32'(sif.sys_reset),    32'd1);
        chk({tag, " ready"},        32'(sif.ready),        32'd0);
        chk({tag, " timeout_err"},  32'(sif.timeout_err),  32'd0);
        chk({tag, " relock_count"}, 32'(sif.relock_count), 32'd0);
    endtask

    task automatic full_sequence();
        run_cycles(4, S_RST, 1'b0);
        run_cycles(8, S_WAIT, 1'b0);
        run_cycles(5, S_HOLD, 1'b0);
        run_cycles(2, S_RUN, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        sif.pll_locked   = 1'b1;
        sif.reconfig_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("por");

        // Power-up with lock already high.
        step  = "powerup";
        reset = 1'b0;
        run_cycles(4, S_RST, 1'b0);
        run_cycles(8, S_WAIT, 1'b0);
        run_cycles(5, S_HOLD, 1'b0);
        run_cycles(3, S_RUN, 1'b0);

        // Short lock glitch is filtered; three low cycles trigger a relock.
        step = "glitch2";
        sif.pll_locked = 1'b0;
        run_cycles(2, S_RUN, 1'b0);
        sif.pll_locked = 1'b1;
        run_cycles(6, S_RUN, 1'b0);
        step = "loss3";
        sif.pll_locked = 1'b0;
        run_cycles(3, S_RUN, 1'b0);
        sif.pll_locked = 1'b1;
        run_cycles(2, S_RUN, 1'b0);
        exp_relock = 8'd1;
        full_sequence();

        // reconfig in RUN, then a pulse inside RESET must not stretch it.
        step = "reconf_run";
        sif.reconfig_req = 1'b1;
        run_cycles(1, S_RUN, 1'b0);
        sif.reconfig_req = 1'b0;
        run_cycles(1, S_RST, 1'b0);
        sif.reconfig_req = 1'b1;
        run_cycles(1, S_RST, 1'b0);
        sif.reconfig_req = 1'b0;
        run_cycles(2, S_RST, 1'b0);
        run_cycles(8, S_WAIT, 1'b0);
        run_cycles(5, S_HOLD, 1'b0);
        run_cycles(2, S_RUN, 1'b0);

        // reconfig on the same edge as loss-filter expiry: no relock count.
        step = "reconf_loss";
        sif.pll_locked = 1'b0;
        run_cycles(3, S_RUN, 1'b0);
        sif.pll_locked = 1'b1;
        run_cycles(1, S_RUN, 1'b0);
        sif.reconfig_req = 1'b1;
        run_cycles(1, S_RUN, 1'b0);
        sif.reconfig_req = 1'b0;
        full_sequence();

        // Lock toggling 7 high / 1 low never qualifies; timeout retries.
        step  = "toggle";
        phase = 0;
        sif.reconfig_req = 1'b1;
        run_cycles(1, S_RUN, 1'b1);
        sif.reconfig_req = 1'b0;
        run_cycles(4, S_RST, 1'b1);
        run_cycles(100, S_WAIT, 1'b1);
        exp_terr   = 1'b1;
        exp_relock = 8'd2;
        sif.pll_locked = 1'b1;
        run_cycles(4, S_RST, 1'b0);
        run_cycles(8, S_WAIT, 1'b0);

        // Lock drop during HOLD returns to WAIT_LOCK without counting.
        step = "hold_drop";
        sif.pll_locked = 1'b0;
        run_cycles(1, S_HOLD, 1'b0);
        sif.pll_locked = 1'b1;
        run_cycles(2, S_HOLD, 1'b0);
        run_cycles(8, S_WAIT, 1'b0);
        run_cycles(2, S_HOLD, 1'b0);

        // Asynchronous reset mid-HOLD, between clock edges.
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        @(negedge clk);
        exp_relock     = 8'd0;
        exp_terr       = 1'b0;
        sif.pll_locked = 1'b0;
        reset          = 1'b0;

        // Lock never arrives: retry every 104 cycles, counter saturates at 255.
        step = "timeout";
        for (int r = 1; r <= 257; r++) begin
            run_cycles(4, S_RST, 1'b0);
            run_cycles(100, S_WAIT, 1'b0);
            exp_terr   = 1'b1;
            exp_relock = (r > 255) ? 8'd255 : 8'(r);
        end
        run_cycles(4, S_RST, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
